muldiv_iter: RTL and testbench
==============================

# muldiv_iter

Parametrised iterative multiply/divide unit for the EX stage. It executes signed and unsigned MULT, DIV, MADD and MSUB-class operations on WIDTH-bit operands and produces a 2*WIDTH-bit {hi, lo} result. Operation is radix-2, one bit per cycle, with start/ready handshaking, a downstream hold, and flush cancellation. The ALU drives it and writes `result` into HI/LO.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH. Minimum 4.
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  cancels any in-flight operation; priority over start
- start  in  1  request; sampled only in IDLE or in DONE with hold=0
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- hilo_in  in  2*WIDTH  accumulator {hi, lo}; sampled with start, used by MADD*/MSUB* only
- hold  in  1  downstream stall; keeps DONE and ready asserted
- busy  out  1  high in BUSY and FIX states
- ready  out  1  result valid; high only in DONE
- result  out  2*WIDTH  {hi, lo}; registered, holds its value until the next FIX
- div_by_zero  out  1  valid with ready; high for DIV/DIVU with src_b==0

## Operation
- States: IDLE, BUSY, FIX, DONE.
- IDLE: start=1 latches op, operands, and hilo_in, then moves to BUSY with counter cleared.
- Signed ops (MULT, DIV, MADD, MSUB): the unit latches the operand magnitudes (unsigned WIDTH-bit abs) and records the result sign(s). Unsigned ops use the operands as-is.
- BUSY, multiply: shift-add over the magnitude multiplier, one bit per edge, into a 2*WIDTH accumulator.
- BUSY, divide: restoring division, one quotient bit per edge, into WIDTH quotient and remainder registers.
- BUSY lasts exactly WIDTH edges, then the unit moves to FIX.
- FIX applies the post-processing below, loads `result`, sets div_by_zero, and moves to DONE:
  - Multiply: negate the product when the operand signs differ (signed ops).
  - Division, signed: the quotient is negated when the signs differ (truncation toward zero). The remainder takes the dividend's sign.
  - Division result layout: lo = quotient, hi = remainder.
  - MADD*/MSUB*: result = hilo_in ± product, modulo 2^(2*WIDTH).
- Divide by zero: lo = all ones, hi = src_a (unsigned latched value, not the magnitude), div_by_zero=1. Latency is unchanged.
- Signed overflow, most-negative / -1: lo = most-negative value, hi = 0. This is the natural wrap and is not flagged.
- DONE exit rules:
  - hold=1: stay in DONE.
  - hold=0 and start=0: go to IDLE.
  - hold=0 and start=1: accept the new operation and go directly to BUSY (back-to-back).
- start in BUSY or FIX is ignored (no queueing). The ALU keeps start high while it stalls on busy.
- flush=1 in any state: IDLE on the next edge; ready and busy drop. The cancelled result is never presented and `result` is not updated. flush together with start does not start an operation.

## Timing
- Reset values: state=IDLE, busy=0, ready=0, result=0, div_by_zero=0. rst mid-operation behaves like flush and also clears `result`.
- Latency, with start high in cycle 0 (accepted on edge 0):
  - busy is high in cycles 1..WIDTH+1.
  - ready is high from cycle WIDTH+2; for WIDTH=32 that is cycle 34.
- Throughput: one operation per WIDTH+2 cycles when start is held high in DONE.
- ready is a level. It stays high for one cycle if hold=0, otherwise for as long as hold=1.
- result and div_by_zero are stable throughout DONE.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002 gives 0xFFFFFFFF_FFFFFFFE. MULTU with the same operands gives 0x00000001_FFFFFFFE. ready first asserts in cycle 34, busy is high in cycles 1-33.
- DIV a=-7 (0xFFFFFFF9), b=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 gives lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF gives lo=0x80000000, hi=0, div_by_zero=0. DIVU a=5, b=0 gives lo=0xFFFFFFFF, hi=5, div_by_zero=1.
- MADD hilo_in=0x00000000_00000010, a=0xFFFFFFFF, b=3 gives 0x00000000_0000000D. MSUBU hilo_in=0, a=1, b=1 gives 0xFFFFFFFF_FFFFFFFF.
- Cancellation and ignored starts:
  - DIV started, then flush in cycle 10: busy=0 in cycle 11 and ready never rises. A new MULTU started in cycle 11 completes correctly in cycle 45.
  - start pulses during BUSY change nothing.
- hold=1 for 3 cycles in DONE keeps ready=1 and result constant. Releasing hold with start=1 begins the next operation with no IDLE cycle. rst asserted mid-MULT returns all outputs to 0 on the next edge.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit: signed/unsigned MULT, DIV, MADD, MSUB
// producing a 2*WIDTH {hi, lo} result after WIDTH iteration cycles plus one fix-up cycle.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  input  logic [2*WIDTH-1:0]   hilo_in,
  input  logic                 hold,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t state, state_next;
  logic   accept;

  // op[0] selects unsigned; op[2] selects accumulate; op[1] is divide or subtract.
  logic op_signed, op_div, op_acc, op_sub;
  assign op_signed = ~op[0];
  assign op_div    = ~op[2] & op[1];
  assign op_acc    = op[2];
  assign op_sub    = op[2] & op[1];

  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  assign accept = start && !flush && (state == IDLE || (state == DONE && !hold));

  // Latched operation context
  logic               div_q, acc_q, sub_q;
  logic               neg_q;      // product / quotient sign
  logic               rem_neg_q;  // remainder follows the dividend sign
  logic               zero_q;     // divide by zero
  logic [WIDTH-1:0]   mag_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   raw_a_q;
  logic [2*WIDTH-1:0] hilo_q;
  logic [2*WIDTH-1:0] work_q;     // {acc_hi, multiplier} or {remainder, quotient}
  logic [CW-1:0]      cnt;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    ready      = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) state_next = BUSY;
        BUSY: if (cnt == LAST) state_next = FIX;
        FIX:  state_next = DONE;
        DONE: if (!hold) state_next = start ? BUSY : IDLE;
        default: state_next = IDLE;
      endcase
    end
    busy  = (state == BUSY) || (state == FIX);
    ready = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] work_next;

  always_comb begin
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, mag_q} : '0);
    div_trial = work_q[2*WIDTH-1:WIDTH-1] - {1'b0, mag_q};
    if (div_q) begin
      // Borrow out means the trial subtraction failed: keep the shifted remainder.
      work_next = div_trial[WIDTH] ? {work_q[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    end else begin
      work_next = {mul_sum, work_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Fix-up
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] fix_result;

  always_comb begin
    prod = neg_q     ? -work_q                   : work_q;
    quo  = neg_q     ? -work_q[WIDTH-1:0]        : work_q[WIDTH-1:0];
    rem  = rem_neg_q ? -work_q[2*WIDTH-1:WIDTH]  : work_q[2*WIDTH-1:WIDTH];
    if (div_q)      fix_result = zero_q ? {raw_a_q, {WIDTH{1'b1}}} : {rem, quo};
    else if (acc_q) fix_result = sub_q ? (hilo_q - prod) : (hilo_q + prod);
    else            fix_result = prod;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: operand and work registers carry no reset; they are always loaded on
  // accept before use, so only the architecturally visible outputs are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      div_q     <= op_div;
      acc_q     <= op_acc;
      sub_q     <= op_sub;
      neg_q     <= op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      rem_neg_q <= op_signed & src_a[WIDTH-1];
      zero_q    <= op_div & (src_b == '0);
      mag_q     <= op_div ? abs_b : abs_a;
      raw_a_q   <= src_a;
      hilo_q    <= hilo_in;
      work_q    <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
      cnt       <= '0;
    end else if (state == BUSY) begin
      work_q    <= work_next;
      cnt       <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (state == FIX && !flush) begin
      result      <= fix_result;
      div_by_zero <= zero_q;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: vector table for arithmetic, hand sequences for
// latency, flush, ignored starts, hold / back-to-back and mid-operation reset.
module tb_muldiv_iter;

  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  logic             clk = 1'b0;
  logic             rst, flush, start, hold;
  logic [2:0]       op;
  logic [W-1:0]     src_a, src_b;
  logic [2*W-1:0]   hilo_in;
  logic             busy, ready, div_by_zero;
  logic [2*W-1:0]   result;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hilo_in(hilo_in), .hold(hold),
    .busy(busy), .ready(ready), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] hilo;
    logic [2*W-1:0] res;
    logic           dbz;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] h);
    op = o; src_a = a; src_b = b; hilo_in = h; start = 1'b1;
  endtask

  // Returns the cycle index (start cycle = 0) in which ready was first seen.
  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!ready && lat < 200);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    logic seen;

    vecs[0]  = '{OP_MULT,  32'hffffffff, 32'h00000002, 64'h0, 64'hffffffff_fffffffe, 1'b0};
    vecs[1]  = '{OP_MULTU, 32'hffffffff, 32'h00000002, 64'h0, 64'h00000001_fffffffe, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hfffffff9, 32'h00000002, 64'h0, 64'hffffffff_fffffffd, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 64'h0, 64'h00000001_00000003, 1'b0};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hffffffff, 64'h0, 64'h00000000_80000000, 1'b0};
    vecs[5]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 64'h0, 64'h00000005_ffffffff, 1'b1};
    vecs[6]  = '{OP_MADD,  32'hffffffff, 32'h00000003, 64'h00000000_00000010, 64'h00000000_0000000d, 1'b0};
    vecs[7]  = '{OP_MSUBU, 32'h00000001, 32'h00000001, 64'h0, 64'hffffffff_ffffffff, 1'b0};
    vecs[8]  = '{OP_MULTU, 32'hffffffff, 32'hffffffff, 64'h0, 64'hfffffffe_00000001, 1'b0};
    vecs[9]  = '{OP_DIV,   32'h00000007, 32'hfffffffe, 64'h0, 64'h00000001_fffffffd, 1'b0};
    vecs[10] = '{OP_DIV,   32'hfffffff9, 32'h00000000, 64'h0, 64'hfffffff9_ffffffff, 1'b1};
    vecs[11] = '{OP_MSUB,  32'hfffffffe, 32'h00000003, 64'h00000000_00000005, 64'h00000000_0000000b, 1'b0};
    vecs[12] = '{OP_MADDU, 32'h00000001, 32'h00000001, 64'hffffffff_ffffffff, 64'h0, 1'b0};
    vecs[13] = '{OP_DIVU,  32'hffffffff, 32'h00000001, 64'h0, 64'h00000000_ffffffff, 1'b0};
    vecs[14] = '{OP_MULT,  32'h80000000, 32'h80000000, 64'h0, 64'h40000000_00000000, 1'b0};

    rst = 1'b1; flush = 1'b0; start = 1'b0; hold = 1'b0;
    op = OP_MULT; src_a = '0; src_b = '0; hilo_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy",  64'(busy),        64'd0);
    check("reset ready", 64'(ready),       64'd0);
    check("reset result", result,          64'd0);
    check("reset dbz",   64'(div_by_zero), 64'd0);

    // Arithmetic vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hilo);
      wait_ready(lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd34);
      check($sformatf("vec%0d result", i), result, vecs[i].res);
      check($sformatf("vec%0d dbz", i), 64'(div_by_zero), 64'(vecs[i].dbz));
    end

    // Cycle-exact busy/ready profile
    @(negedge clk);
    issue(OP_MULT, 32'hffffffff, 32'h00000002, 64'h0);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("profile busy c%0d", c),  64'(busy),  64'(c <= 33));
      check($sformatf("profile ready c%0d", c), 64'(ready), 64'(c == 34));
    end
    check("profile result", result, 64'hffffffff_fffffffe);

    // Flush of an in-flight DIV in cycle 10, new MULTU in cycle 11
    @(negedge clk);
    issue(OP_DIV, 32'd100, 32'd3, 64'h0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check("flush busy",   64'(busy),  64'd0);
    check("flush ready",  64'(ready), 64'd0);
    check("flush result kept", result, 64'hffffffff_fffffffe);
    issue(OP_MULTU, 32'd6, 32'd7, 64'h0);
    wait_ready(lat);
    check("post-flush ready cycle", 64'(11 + lat), 64'd45);
    check("post-flush result", result, 64'd42);

    // start pulses during BUSY with different operands are ignored
    @(negedge clk);
    issue(OP_MULTU, 32'd3, 32'd5, 64'h0);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 5 || c == 20) begin
        issue(OP_DIVU, 32'd99, 32'd0, 64'h12345678_9abcdef0);
      end else begin
        start = 1'b0;
      end
    end
    check("ignored-start ready",  64'(ready), 64'd1);
    check("ignored-start result", result, 64'd15);
    check("ignored-start dbz",    64'(div_by_zero), 64'd0);

    // hold for 3 cycles, then release with start for a back-to-back op
    @(negedge clk);
    issue(OP_MULTU, 32'd9, 32'd9, 64'h0);
    wait_ready(lat);
    check("hold first result", result, 64'd81);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold ready %0d", k),  64'(ready), 64'd1);
      check($sformatf("hold result %0d", k), result, 64'd81);
    end
    hold = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 64'h0);
    @(negedge clk);
    start = 1'b0;
    check("b2b busy",  64'(busy),  64'd1);
    check("b2b ready", 64'(ready), 64'd0);
    wait_ready(lat);
    check("b2b latency", 64'(lat + 1), 64'd34);
    check("b2b result",  result, 64'h00000002_0000000e);

    // Reset mid-MULT clears every output
    @(negedge clk);
    issue(OP_DIVU, 32'd5, 32'd0, 64'h0);
    wait_ready(lat);
    check("pre-reset dbz", 64'(div_by_zero), 64'd1);
    @(negedge clk);
    issue(OP_MULT, 32'd123, 32'd456, 64'h0);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-reset busy",   64'(busy),        64'd0);
    check("mid-reset ready",  64'(ready),       64'd0);
    check("mid-reset result", result,           64'd0);
    check("mid-reset dbz",    64'(div_by_zero), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | ready | busy;
    end
    check("post-reset idle", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
